hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Parametrised successor to the single-cycle load-use bubble generator in the 5-stage MIPS core.
- Detects load-use hazards between ID and EX, and holds the bubble for a configurable number of cycles so the unit also serves deeper memory pipelines.
- Freezes the whole pipeline while a multi-cycle data memory is not ready, honours branch/exception flushes, and keeps saturating stall/freeze performance counters.
- Sits beside the ID stage; drives the PC, IF/ID and ID/EX pipeline-register controls.

Parameters:
- REG_AW, 5, register-address width; register 0 is never a hazard source.
- LOAD_LAT, 1, bubble cycles per load-use hazard; legal range 1..7.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_read_id  in  1  ID instruction reads rs.
- rt_read_id  in  1  ID instruction reads rt.
- rs_id  in  REG_AW  rs address in ID.
- rt_id  in  REG_AW  rt address in ID.
- reg_we_ex  in  1  EX instruction writes the register file.
- rd_ex  in  REG_AW  EX destination register.
- opcode_ex  in  6  EX instruction[31:26].
- mem_req_mem  in  1  MEM stage is performing a data access.
- mem_ready  in  1  data memory completes the access this cycle.
- flush  in  1  branch taken or exception; squashes IF and ID.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_hold  out  1  hold PC.
- ifid_hold  out  1  hold IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX.
- pipe_freeze  out  1  hold every pipeline register.
- stall_cycles  out  CNT_W  count of bubble cycles.
- freeze_cycles  out  CNT_W  count of freeze cycles.

Behaviour:
- Reset: async on rst_n low. State becomes IDLE, remain=0, both counters 0. While rst_n is low, all four control outputs are forced to 0.
- is_load is true when opcode_ex is one of LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25.
- hit is true when reg_we_ex && rd_ex!=0 && is_load && ((rs_read_id && rs_id==rd_ex) || (rt_read_id && rt_id==rd_ex)).
- freeze = mem_req_mem && !mem_ready.
  - pipe_freeze = freeze, pc_hold = freeze or bubble, ifid_hold = freeze or bubble, idex_bubble = bubble && !freeze.
- The unit has two states, IDLE and LOAD_WAIT; remain is a 3-bit counter.
- IDLE:
  - bubble = hit && !flush.
  - If bubble, !freeze and LOAD_LAT>1: go to LOAD_WAIT with remain=LOAD_LAT-1.
  - Otherwise stay in IDLE.
  - With LOAD_LAT=1 the behaviour matches the classic single-bubble generator.
- LOAD_WAIT:
  - bubble = !flush, independent of hit, because the load has already left EX.
  - If !freeze: remain decrements; on reaching 0, go to IDLE.
  - The final LOAD_WAIT cycle is the last bubble. The ID instruction issues on the following cycle.
- Freeze has priority over everything else.
  - The state, remain and the bubble decision are held unchanged.
  - idex_bubble is 0 because ID/EX is frozen.
  - flush is ignored during freeze; the flush producer must hold flush until freeze drops.
- flush without freeze: bubble=0, state goes to IDLE, remain=0 the next cycle. The squashed ID instruction needs no bubble.
- hit and flush in the same cycle: flush wins, no bubble.
- Counters:
  - stall_cycles increments on each cycle with idex_bubble=1.
  - freeze_cycles increments on each cycle with pipe_freeze=1.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr zeroes both counters on the next edge and overrides that cycle's increment.
- Latency: control outputs are combinational from inputs and state, with zero-cycle latency. Counters update one cycle after the event.

Decomposition:
- Shared package cpu_pkg holds the opcode constants OP_LB, OP_LH, OP_LW, OP_LBU and OP_LHU.
- cpu_pkg also holds the state enum hsu_state_t (IDLE, LOAD_WAIT) and the is_load_op() function.
- One sub-module, sat_counter (parameter W, inputs inc and clr), is instantiated twice for the performance counters.

Test Plan:
- LOAD_LAT=1: EX lw rd=8 with reg_we_ex=1, ID rs_read_id=1 rs_id=8 -> exactly 1 cycle of idex_bubble, pc_hold and ifid_hold all =1; stall_cycles=1 afterwards.
- rd_ex=0, or reg_we_ex=0, or opcode 0x2B (sw), or rs_read_id=0 with a matching address -> no bubble, counters unchanged.
- LOAD_LAT=3: lbu (0x24) to rt=5, ID reads rt=5 -> idex_bubble high for 3 consecutive cycles even though EX then holds NOPs; returns to IDLE; stall_cycles=3.
- LOAD_LAT=3, mem_req_mem=1 and mem_ready=0 for 2 cycles during the 2nd bubble cycle:
  - pipe_freeze=1 for 2 cycles with idex_bubble=0;
  - total idex_bubble cycles remain 3;
  - freeze_cycles=2.
- LOAD_LAT=3, flush asserted in the 2nd bubble cycle -> bubble drops that cycle, state IDLE next cycle; hit and flush in the same cycle -> no bubble.
- CNT_W=4: 20 consecutive bubble cycles -> stall_cycles saturates at 15; cnt_clr=1 -> 0 next edge; rst_n low mid-LOAD_WAIT -> outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load opcodes, hazard-unit state encoding and the load-opcode decoder.
package cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } hsu_state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard/stall unit: ID/EX/MEM observations in, pipeline controls and counters out.
interface hazard_stall_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              rs_read_id;
  logic              rt_read_id;
  logic [REG_AW-1:0] rs_id;
  logic [REG_AW-1:0] rt_id;
  logic              reg_we_ex;
  logic [REG_AW-1:0] rd_ex;
  logic [5:0]        opcode_ex;
  logic              mem_req_mem;
  logic              mem_ready;
  logic              flush;
  logic              cnt_clr;
  logic              pc_hold;
  logic              ifid_hold;
  logic              idex_bubble;
  logic              pipe_freeze;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  freeze_cycles;

  modport master (
    output rs_read_id, rt_read_id, rs_id, rt_id, reg_we_ex, rd_ex, opcode_ex,
           mem_req_mem, mem_ready, flush, cnt_clr,
    input  pc_hold, ifid_hold, idex_bubble, pipe_freeze, stall_cycles, freeze_cycles
  );

  modport slave (
    input  rs_read_id, rt_read_id, rs_id, rt_id, reg_we_ex, rd_ex, opcode_ex,
           mem_req_mem, mem_ready, flush, cnt_clr,
    output pc_hold, ifid_hold, idex_bubble, pipe_freeze, stall_cycles, freeze_cycles
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard bubble generator with LOAD_LAT-cycle bubbles, memory-wait freeze and stall/freeze counters.
module hazard_stall_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_stall_unit_if.slave bus
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  hsu_state_t        r_state;
  hsu_state_t        w_nextState;
  logic [2:0]        r_remain;
  logic [2:0]        w_nextRemain;
  logic [REG_AW-1:0] w_rd;
  logic              w_hit;
  logic              w_freeze;
  logic              w_bubble;

  assign w_rd     = bus.rd_ex;
  assign w_freeze = bus.mem_req_mem && !bus.mem_ready;
  assign w_hit    = bus.reg_we_ex && (w_rd != '0) && is_load_op(bus.opcode_ex) &&
                    ((bus.rs_read_id && (bus.rs_id == w_rd)) ||
                     (bus.rt_read_id && (bus.rt_id == w_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_remain <= 3'd0;
    end else begin
      r_state  <= w_nextState;
      r_remain <= w_nextRemain;
    end
  end

  // In LOAD_WAIT the load has already left EX, so the bubble no longer depends on hit.
  always_comb begin
    w_nextState  = r_state;
    w_nextRemain = r_remain;
    w_bubble     = 1'b0;
    case (r_state)
      IDLE:      w_bubble = w_hit && !bus.flush;
      LOAD_WAIT: w_bubble = !bus.flush;
      default:   w_bubble = 1'b0;
    endcase
    if (!w_freeze) begin
      if (bus.flush) begin
        w_nextState  = IDLE;
        w_nextRemain = 3'd0;
      end else if (r_state == IDLE) begin
        if (w_bubble && (LOAD_LAT > 1)) begin
          w_nextState  = LOAD_WAIT;
          w_nextRemain = LAT_M1;
        end
      end else begin
        w_nextRemain = r_remain - 3'd1;
        if (r_remain == 3'd1) w_nextState = IDLE;
      end
    end
  end

  assign bus.pipe_freeze = rst_n && w_freeze;
  assign bus.pc_hold     = rst_n && (w_freeze || w_bubble);
  assign bus.ifid_hold   = rst_n && (w_freeze || w_bubble);
  assign bus.idex_bubble = rst_n && w_bubble && !w_freeze;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.idex_bubble),
    .clr   (bus.cnt_clr),
    .count (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_freezeCnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.pipe_freeze),
    .clr   (bus.cnt_clr),
    .count (bus.freeze_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Drives two hazard_stall_unit instances (LOAD_LAT=3/CNT_W=4 and LOAD_LAT=1/CNT_W=32) and checks them against an owed-bubble model.
module tb_hazard_stall_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Model: pend = bubble cycles still owed after the current one.
  int     pend[2]     = '{0, 0};
  int     lat[2]      = '{3, 1};
  longint stallCnt[2] = '{0, 0};
  longint frzCnt[2]   = '{0, 0};
  longint maxCnt[2]   = '{15, 64'h0000_0000_FFFF_FFFF};

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.REG_AW(5), .CNT_W(4))  busA ();
  hazard_stall_unit_if #(.REG_AW(5), .CNT_W(32)) busB ();

  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  hazard_stall_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rsR, input bit rtR, input logic [4:0] rs, input logic [4:0] rt,
                               input bit we, input logic [4:0] rd, input logic [5:0] op,
                               input bit req, input bit rdy, input bit fl, input bit clr);
    busA.rs_read_id = rsR;  busB.rs_read_id = rsR;
    busA.rt_read_id = rtR;  busB.rt_read_id = rtR;
    busA.rs_id = rs;        busB.rs_id = rs;
    busA.rt_id = rt;        busB.rt_id = rt;
    busA.reg_we_ex = we;    busB.reg_we_ex = we;
    busA.rd_ex = rd;        busB.rd_ex = rd;
    busA.opcode_ex = op;    busB.opcode_ex = op;
    busA.mem_req_mem = req; busB.mem_req_mem = req;
    busA.mem_ready = rdy;   busB.mem_ready = rdy;
    busA.flush = fl;        busB.flush = fl;
    busA.cnt_clr = clr;     busB.cnt_clr = clr;
  endtask

  task automatic checkZero(input string when);
    checkOutput({when, " A.pipe_freeze"},   32'(busA.pipe_freeze), 0);
    checkOutput({when, " A.pc_hold"},       32'(busA.pc_hold), 0);
    checkOutput({when, " A.ifid_hold"},     32'(busA.ifid_hold), 0);
    checkOutput({when, " A.idex_bubble"},   32'(busA.idex_bubble), 0);
    checkOutput({when, " A.stall_cycles"},  32'(busA.stall_cycles), 0);
    checkOutput({when, " A.freeze_cycles"}, 32'(busA.freeze_cycles), 0);
    checkOutput({when, " B.pipe_freeze"},   32'(busB.pipe_freeze), 0);
    checkOutput({when, " B.pc_hold"},       32'(busB.pc_hold), 0);
    checkOutput({when, " B.ifid_hold"},     32'(busB.ifid_hold), 0);
    checkOutput({when, " B.idex_bubble"},   32'(busB.idex_bubble), 0);
    checkOutput({when, " B.stall_cycles"},  busB.stall_cycles, 0);
    checkOutput({when, " B.freeze_cycles"}, busB.freeze_cycles, 0);
  endtask

  // One clock cycle: drive at +1 after the edge, check at +2, advance the model on the edge.
  task automatic cycle(input bit rsR, input bit rtR, input logic [4:0] rs, input logic [4:0] rt,
                       input bit we, input logic [4:0] rd, input logic [5:0] op,
                       input bit req, input bit rdy, input bit fl, input bit clr);
    bit isLoad, hit, frz;
    bit expBub[2];
    applyStimulus(rsR, rtR, rs, rt, we, rd, op, req, rdy, fl, clr);
    #1;
    isLoad = (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
    hit    = we && (rd != 0) && isLoad && ((rsR && rs == rd) || (rtR && rt == rd));
    frz    = req && !rdy;
    for (int i = 0; i < 2; i++) expBub[i] = !frz && !fl && (pend[i] > 0 || hit);

    checkOutput("A.pipe_freeze",   32'(busA.pipe_freeze), 32'(frz));
    checkOutput("A.pc_hold",       32'(busA.pc_hold), 32'(frz || expBub[0]));
    checkOutput("A.ifid_hold",     32'(busA.ifid_hold), 32'(frz || expBub[0]));
    checkOutput("A.idex_bubble",   32'(busA.idex_bubble), 32'(expBub[0]));
    checkOutput("A.stall_cycles",  32'(busA.stall_cycles), 32'(stallCnt[0]));
    checkOutput("A.freeze_cycles", 32'(busA.freeze_cycles), 32'(frzCnt[0]));
    checkOutput("B.pipe_freeze",   32'(busB.pipe_freeze), 32'(frz));
    checkOutput("B.pc_hold",       32'(busB.pc_hold), 32'(frz || expBub[1]));
    checkOutput("B.ifid_hold",     32'(busB.ifid_hold), 32'(frz || expBub[1]));
    checkOutput("B.idex_bubble",   32'(busB.idex_bubble), 32'(expBub[1]));
    checkOutput("B.stall_cycles",  busB.stall_cycles, 32'(stallCnt[1]));
    checkOutput("B.freeze_cycles", busB.freeze_cycles, 32'(frzCnt[1]));

    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!frz) begin
        if (fl)               pend[i] = 0;
        else if (pend[i] > 0) pend[i] = pend[i] - 1;
        else if (hit)         pend[i] = lat[i] - 1;
      end
      if (clr) begin
        stallCnt[i] = 0;
        frzCnt[i]   = 0;
      end else begin
        if (expBub[i] && stallCnt[i] < maxCnt[i]) stallCnt[i] = stallCnt[i] + 1;
        if (frz && frzCnt[i] < maxCnt[i])         frzCnt[i]   = frzCnt[i] + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle with hazard inputs still applied.
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1 checkZero("reset");
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; stallCnt[i] = 0; frzCnt[i] = 0;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] ops[8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B, 6'h00, 6'h0F};
    bit fz;
    applyStimulus(0, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1 checkZero("init");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] lw load-use hit on rs");
    cycle(1, 0, 8, 0, 1, 8, 6'h23, 0, 1, 0, 0);
    idle(4);

    $display("[TB] non-hazard variants");
    cycle(1, 0, 0, 0, 1, 0, 6'h23, 0, 1, 0, 0);
    cycle(1, 0, 8, 0, 0, 8, 6'h23, 0, 1, 0, 0);
    cycle(1, 0, 8, 0, 1, 8, 6'h2B, 0, 1, 0, 0);
    cycle(0, 1, 8, 9, 1, 8, 6'h23, 0, 1, 0, 0);
    idle(1);

    $display("[TB] lbu hit on rt");
    cycle(0, 1, 0, 5, 1, 5, 6'h24, 0, 1, 0, 0);
    idle(4);

    $display("[TB] freeze during second bubble cycle");
    cycle(0, 1, 0, 5, 1, 5, 6'h24, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 6'h00, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 6'h00, 1, 0, 0, 0);
    idle(4);

    $display("[TB] flush in second bubble cycle, then hit with flush");
    cycle(1, 0, 3, 0, 1, 3, 6'h21, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 6'h00, 0, 1, 1, 0);
    idle(3);
    cycle(1, 0, 3, 0, 1, 3, 6'h20, 0, 1, 1, 0);
    idle(2);

    $display("[TB] saturation and clear");
    for (int k = 0; k < 20; k++) cycle(1, 1, 7, 7, 1, 7, 6'h25, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 6'h00, 0, 1, 0, 1);
    idle(2);

    $display("[TB] reset in the middle of a load wait");
    cycle(1, 0, 8, 0, 1, 8, 6'h23, 0, 1, 0, 0);
    applyStimulus(1, 0, 8, 0, 1, 8, 6'h23, 0, 1, 0, 0);
    doReset();
    idle(2);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 1500; n++) begin
      fz = ($urandom_range(0, 99) < 15);
      cycle($urandom_range(0, 1), $urandom_range(0, 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)],
            fz || ($urandom_range(0, 3) == 0), !fz,
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
